button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce.sv | 105 ++++++++++
 tb/tb_button_debounce.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Push-button debouncer: 2-flop synchroniser, four-state stability FSM, registered
// level/strobe outputs and an 8-bit wrapping press counter.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 120000,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       button_raw,
   output logic       pressed,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic [7:0] press_count
);

   localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      StReleased,
      StWaitPress,
      StPressed,
      StWaitRelease
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            sync1_q, sync2_q;
   logic            pressed_q, pressed_d;
   logic            press_pulse_q, release_pulse_q;
   logic [7:0]      press_count_q, press_count_d;
   logic            level;
   logic            enter_pressed, enter_released;

   // Normalise so that level = 1 means pressed regardless of pad polarity.
   assign level = sync2_q ^ ACTIVE_LOW;

   always_comb begin
      state_d        = state_q;
      cnt_d          = '0;
      enter_pressed  = 1'b0;
      enter_released = 1'b0;
      case (state_q)
         StReleased: begin
            if (level) state_d = StWaitPress;
         end
         StWaitPress: begin
            if (!level) begin
               state_d = StReleased;
            end else if (cnt_q == CntLast) begin
               state_d       = StPressed;
               enter_pressed = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StPressed: begin
            if (!level) state_d = StWaitRelease;
         end
         StWaitRelease: begin
            if (level) begin
               state_d = StPressed;
            end else if (cnt_q == CntLast) begin
               state_d        = StReleased;
               enter_released = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StReleased;
      endcase
   end

   // Outputs are registered from the next state so they track the state register exactly.
   assign pressed_d     = (state_d == StPressed) || (state_d == StWaitRelease);
   assign press_count_d = press_count_q + {7'd0, enter_pressed};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q         <= ACTIVE_LOW;
         sync2_q         <= ACTIVE_LOW;
         state_q         <= StReleased;
         cnt_q           <= '0;
         pressed_q       <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         press_count_q   <= 8'd0;
      end else begin
         sync1_q         <= button_raw;
         sync2_q         <= sync1_q;
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         pressed_q       <= pressed_d;
         press_pulse_q   <= enter_pressed;
         release_pulse_q <= enter_released;
         press_count_q   <= press_count_d;
      end
   end

   assign pressed       = pressed_q;
   assign press_pulse   = press_pulse_q;
   assign release_pulse = release_pulse_q;
   assign press_count   = press_count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce (DEBOUNCE_CYCLES = 4, active-low pad).
module tb_button_debounce;

   localparam int unsigned Dc  = 4;
   // Change seen by edge E = cyc+1; pulse visible after edge E + Dc + 2.
   localparam int          Lat = Dc + 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       button_raw = 1'b1;
   logic       pressed, press_pulse, release_pulse;
   logic [7:0] press_count;

   button_debounce #(
      .DEBOUNCE_CYCLES(Dc),
      .ACTIVE_LOW     (1'b1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .button_raw   (button_raw),
      .pressed      (pressed),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .press_count  (press_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         is_press;
      int         cyc;
      logic [7:0] count;
   } ev_t;

   ev_t        sb[$];
   int         checks = 0;
   int         failures = 0;
   int         npress = 0;
   int         exp_npress = 0;
   logic [7:0] exp_count = 8'd0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Change the pad at a negedge and, if it should be accepted, queue the expected strobe.
   task automatic drive(input logic val, input bit expect_ev, input int hold);
      ev_t e;
      @(negedge clk);
      button_raw = val;
      if (expect_ev) begin
         e.is_press = (val == 1'b0);
         e.cyc      = cyc + Lat;
         if (e.is_press) begin
            exp_count = exp_count + 8'd1;
            exp_npress++;
         end
         e.count = exp_count;
         sb.push_back(e);
      end
      repeat (hold) @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      #2 rst_n = 1'b0;
      exp_count = 8'd0;
      #1;
      chk("rst_pressed", int'(pressed), 0);
      chk("rst_press_pulse", int'(press_pulse), 0);
      chk("rst_release_pulse", int'(release_pulse), 0);
      chk("rst_press_count", int'(press_count), 0);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: pops the scoreboard whenever the DUT strobes.
   initial begin
      ev_t  e;
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev = pressed;
         end else begin
            if (press_pulse && release_pulse) chk("both_pulses", 1, 0);
            if (press_pulse || release_pulse) begin
               if (press_pulse) npress++;
               if (sb.size() == 0) begin
                  chk("unexpected_pulse_at_cyc", cyc, -1);
               end else begin
                  e = sb.pop_front();
                  chk("pulse_kind", int'(press_pulse), int'(e.is_press));
                  chk("pulse_cycle", cyc, e.cyc);
                  chk("pulse_count", int'(press_count), int'(e.count));
                  chk("pulse_level", int'(pressed), int'(e.is_press));
               end
            end
            if (pressed != prev)
               chk("edge_has_pulse", int'(pressed ? press_pulse : release_pulse), 1);
            prev = pressed;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #1;
      chk("init_pressed", int'(pressed), 0);
      chk("init_press_count", int'(press_count), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Single-cycle glitches every 3 cycles
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         button_raw = (i % 3 == 0) ? 1'b0 : 1'b1;
      end
      drive(1'b1, 1'b0, 10);
      chk("glitch_pressed", int'(pressed), 0);
      chk("glitch_press_count", int'(press_count), 0);

      // Clean press then release
      drive(1'b0, 1'b1, 20);
      chk("clean_pressed", int'(pressed), 1);
      chk("clean_press_count", int'(press_count), 1);
      drive(1'b1, 1'b1, 20);
      chk("release_pressed", int'(pressed), 0);
      chk("release_press_count", int'(press_count), 1);

      // Bounce: 0 x3, 1 x1, then 0 held
      drive(1'b0, 1'b0, 3);
      drive(1'b1, 1'b0, 1);
      drive(1'b0, 1'b1, 20);
      chk("bounce_pressed", int'(pressed), 1);
      chk("bounce_press_count", int'(press_count), 2);
      drive(1'b1, 1'b1, 20);

      // Reset mid-debounce with the button held through reset
      drive(1'b0, 1'b0, 2);
      do_reset(2);
      @(negedge clk);
      begin
         ev_t e;
         rst_n      = 1'b1;
         e.is_press = 1'b1;
         e.cyc      = cyc + Lat;
         exp_count  = exp_count + 8'd1;
         exp_npress++;
         e.count    = exp_count;
         sb.push_back(e);
      end
      repeat (20) @(negedge clk);
      chk("rst_hold_pressed", int'(pressed), 1);
      drive(1'b1, 1'b1, 20);

      // Wrap: 256 press/release pairs from reset
      do_reset(2);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 256; i++) begin
         drive(1'b0, 1'b1, 10);
         drive(1'b1, 1'b1, 10);
      end
      chk("wrap_press_count", int'(press_count), 0);
      chk("total_press_pulses", npress, exp_npress);

      repeat (20) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
